// File: rtl/sid_bus_master.sv
// SID host-bus initiator: free-running phi2, power-on /RES pulse, and one
// register read or write per phi2 cycle taken from a valid/ready request port.
module sid_bus_master #(
   parameter int unsigned PHI2_DIV   = 24,
   parameter int unsigned HOLD_CLKS  = 1,
   parameter int unsigned RES_CYCLES = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic       req_we,
   input  logic [4:0] req_addr,
   input  logic [7:0] req_wdata,
   output logic       rsp_valid,
   output logic [7:0] rsp_rdata,
   output logic       phi2_o,
   output logic       res_n_o,
   output logic       cs_n_o,
   output logic       r_w_n_o,
   output logic [4:0] addr_o,
   output logic [7:0] data_o,
   output logic       data_oe,
   input  logic [7:0] data_i
);

   localparam int unsigned PW = $clog2(PHI2_DIV);
   localparam int unsigned CW = $clog2(RES_CYCLES + 1);

   localparam logic [PW-1:0] PH_LAST   = PW'(PHI2_DIV - 1);
   localparam logic [PW-1:0] PH_RISE   = PW'(PHI2_DIV / 2);
   localparam logic [PW-1:0] PH_LAUNCH = PW'(HOLD_CLKS);
   localparam logic [CW-1:0] RES_DONE  = CW'(RES_CYCLES);

   typedef enum logic {
      ST_RESET,
      ST_RUN
   } state_t;

   state_t        state_q, state_d;
   logic [PW-1:0] phase_q, phase_d;
   logic [CW-1:0] falls_q, falls_d;
   logic          phi2_q, phi2_d;
   logic          cs_n_q, cs_n_d;
   logic          r_w_n_q, r_w_n_d;
   logic [4:0]    addr_q, addr_d;
   logic [7:0]    data_q, data_d;
   logic          oe_q, oe_d;
   logic          rsp_v_q, rsp_v_d;
   logic [7:0]    rdata_q, rdata_d;
   logic          ready_q, ready_d;
   logic          pend_v_q, pend_v_d;
   logic          pend_we_q, pend_we_d;
   logic [4:0]    pend_addr_q, pend_addr_d;
   logic [7:0]    pend_wdata_q, pend_wdata_d;
   logic          cur_v_q, cur_v_d;
   logic          cur_we_q, cur_we_d;
   logic [7:0]    cur_wdata_q, cur_wdata_d;

   logic wrap, launch, rise, accept;

   // Next-state for phase timing, reset sequencing, request slots and bus outputs.
   // Every output register is loaded from phase_d so it changes on the same edge
   // as the phase it belongs to.
   always_comb begin
      phase_d      = (phase_q == PH_LAST) ? '0 : phase_q + PW'(1);
      wrap         = (phase_q == PH_LAST);
      launch       = (phase_d == PH_LAUNCH);
      rise         = (phase_d == PH_RISE);
      accept       = req_valid & ready_q;

      state_d      = state_q;
      falls_d      = falls_q;
      phi2_d       = (phase_d >= PH_RISE);
      cs_n_d       = cs_n_q;
      r_w_n_d      = r_w_n_q;
      addr_d       = addr_q;
      data_d       = data_q;
      oe_d         = oe_q;
      rsp_v_d      = 1'b0;
      rdata_d      = rdata_q;
      pend_v_d     = pend_v_q;
      pend_we_d    = pend_we_q;
      pend_addr_d  = pend_addr_q;
      pend_wdata_d = pend_wdata_q;
      cur_v_d      = cur_v_q;
      cur_we_d     = cur_we_q;
      cur_wdata_d  = cur_wdata_q;

      if (wrap && (falls_q != RES_DONE)) begin
         falls_d = falls_q + CW'(1);
      end

      if ((state_q == ST_RESET) && launch && (falls_q == RES_DONE)) begin
         state_d = ST_RUN;
      end

      // Accept and launch never coincide: accept needs an empty slot, launch a full one.
      if (accept) begin
         pend_v_d     = 1'b1;
         pend_we_d    = req_we;
         pend_addr_d  = req_addr;
         pend_wdata_d = req_wdata;
      end

      if (launch && (state_q == ST_RUN)) begin
         oe_d = 1'b0;
         if (pend_v_q) begin
            addr_d      = pend_addr_q;
            r_w_n_d     = ~pend_we_q;
            cs_n_d      = 1'b0;
            cur_v_d     = 1'b1;
            cur_we_d    = pend_we_q;
            cur_wdata_d = pend_wdata_q;
            pend_v_d    = 1'b0;
         end else begin
            cs_n_d  = 1'b1;
            r_w_n_d = 1'b1;
            cur_v_d = 1'b0;
         end
      end

      if (rise && cur_v_q && cur_we_q) begin
         data_d = cur_wdata_q;
         oe_d   = 1'b1;
      end

      // Read data is captured on the last clk of phi2 high, the same edge that
      // raises rsp_valid at the phi2 fall.
      if (wrap && cur_v_q) begin
         rsp_v_d = 1'b1;
         rdata_d = cur_we_q ? '0 : data_i;
      end

      ready_d = (state_d == ST_RUN) & ~pend_v_d;
   end

   // Reset-sequence state register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_RESET;
      end else begin
         state_q <= state_d;
      end
   end

   // Phase counter, slots and registered bus/response outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         phase_q      <= '0;
         falls_q      <= '0;
         phi2_q       <= 1'b0;
         cs_n_q       <= 1'b1;
         r_w_n_q      <= 1'b1;
         addr_q       <= '0;
         data_q       <= '0;
         oe_q         <= 1'b0;
         rsp_v_q      <= 1'b0;
         rdata_q      <= '0;
         ready_q      <= 1'b0;
         pend_v_q     <= 1'b0;
         pend_we_q    <= 1'b0;
         pend_addr_q  <= '0;
         pend_wdata_q <= '0;
         cur_v_q      <= 1'b0;
         cur_we_q     <= 1'b0;
         cur_wdata_q  <= '0;
      end else begin
         phase_q      <= phase_d;
         falls_q      <= falls_d;
         phi2_q       <= phi2_d;
         cs_n_q       <= cs_n_d;
         r_w_n_q      <= r_w_n_d;
         addr_q       <= addr_d;
         data_q       <= data_d;
         oe_q         <= oe_d;
         rsp_v_q      <= rsp_v_d;
         rdata_q      <= rdata_d;
         ready_q      <= ready_d;
         pend_v_q     <= pend_v_d;
         pend_we_q    <= pend_we_d;
         pend_addr_q  <= pend_addr_d;
         pend_wdata_q <= pend_wdata_d;
         cur_v_q      <= cur_v_d;
         cur_we_q     <= cur_we_d;
         cur_wdata_q  <= cur_wdata_d;
      end
   end

   assign req_ready = ready_q;
   assign rsp_valid = rsp_v_q;
   assign rsp_rdata = rdata_q;
   assign phi2_o    = phi2_q;
   assign res_n_o   = (state_q == ST_RUN);
   assign cs_n_o    = cs_n_q;
   assign r_w_n_o   = r_w_n_q;
   assign addr_o    = addr_q;
   assign data_o    = data_q;
   assign data_oe   = oe_q;

endmodule
